// File: rtl/uart_fifo_bridge_pkg.sv
// Shared definitions for the UART FIFO bridge: the default character width
// and the TX handshake state encoding.
package uart_fifo_bridge_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STROBE,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO with an explicit occupancy counter.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic                         pop,
  input  logic [Width-1:0]             din,
  output logic [Width-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   level
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == LvlW'(Depth));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered bridge between the UART strobe interface and a host valid/ready stream.
// Define UART_LOOPBACK_EN to let LOOPBACK route received bytes straight back to TX.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int Width   = DEFAULT_WIDTH,
  parameter int RxDepth = 16,
  parameter int TxDepth = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  output logic [Width-1:0]              U_DIN,
  output logic                          U_OE,
  input  logic                          U_RDY,
  input  logic [Width-1:0]              U_DOUT,
  input  logic                          U_INT,
  input  logic [Width-1:0]              TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  output logic [Width-1:0]              RX_DATA,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic                          RX_OVR,
  input  logic                          OVR_CLR,
  output logic [$clog2(RxDepth+1)-1:0]  RX_LEVEL,
  output logic [$clog2(TxDepth+1)-1:0]  TX_LEVEL,
  input  logic                          LOOPBACK
);

  tx_state_t        state;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [Width-1:0] tx_wdata, tx_head;
  logic             loop_active;
  logic             ovr_set;

  sync_fifo #(.Width(Width), .Depth(RxDepth)) u_rx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (U_DOUT),
    .dout  (RX_DATA),
    .full  (rx_full),
    .empty (rx_empty),
    .level (RX_LEVEL)
  );

  sync_fifo #(.Width(Width), .Depth(TxDepth)) u_tx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (TX_LEVEL)
  );

`ifdef UART_LOOPBACK_EN
  logic loop_q;

  // The mode is registered so a host write in the switching cycle still lands.
  always_ff @(posedge CLK) begin
    if (RST) loop_q <= 1'b0;
    else     loop_q <= LOOPBACK;
  end

  assign loop_active = loop_q;
`else
  logic loopback_unused;

  assign loopback_unused = LOOPBACK;
  assign loop_active     = 1'b0;
`endif

  assign RX_VALID = !rx_empty;
  assign rx_pop   = RX_READY && !rx_empty;
  assign TX_READY = !tx_full && !loop_active;
  assign tx_pop   = (state == TX_IDLE) && !tx_empty && U_RDY;

  always_comb begin
    rx_push  = 1'b0;
    tx_push  = TX_VALID && TX_READY;
    tx_wdata = TX_DATA;
    ovr_set  = 1'b0;
    if (loop_active) begin
      tx_push  = U_INT;
      tx_wdata = U_DOUT;
      ovr_set  = U_INT && tx_full && !tx_pop;
    end else begin
      rx_push  = U_INT;
      ovr_set  = U_INT && rx_full && !rx_pop;
    end
  end

  // A drop in the same cycle as a clear wins, so no overrun is ever lost.
  always_ff @(posedge CLK) begin
    if (RST)
      RX_OVR <= 1'b0;
    else if (ovr_set)
      RX_OVR <= 1'b1;
    else if (OVR_CLR)
      RX_OVR <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= TX_IDLE;
      U_OE  <= 1'b0;
      U_DIN <= '0;
    end else begin
      U_OE <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (tx_pop) begin
            U_DIN <= tx_head;
            U_OE  <= 1'b1;
            state <= TX_STROBE;
          end
        end
        TX_STROBE:    state <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (!U_RDY) state <= TX_WAIT_IDLE;
        TX_WAIT_IDLE: if (U_RDY)  state <= TX_IDLE;
        default:      state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Buffered byte bridge between the existing UART core's single-byte strobe interface (DIN/OE/RDY, DOUT/INT) and a host-side valid/ready stream interface. It adds parametrised RX and TX FIFOs, overrun detection, and fill-level status, and replaces the unbuffered register-to-register echo the SoC top uses today. It is instantiated in the SoC top between the UART and the future CPU bus or echo logic.

Parameters:
Width, 8, data bits per character; must match UART data width.
RxDepth, 16, RX FIFO entries; power of two, 2 or more.
TxDepth, 16, TX FIFO entries; power of two, 2 or more.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous, active-high reset.
U_DIN  out  Width  byte to UART transmitter.
U_OE  out  1  one-cycle transmit strobe to UART.
U_RDY  in  1  UART transmitter idle.
U_DOUT  in  Width  UART received byte; valid when U_INT=1.
U_INT  in  1  one-cycle receive-done pulse.
TX_DATA  in  Width  host byte to send.
TX_VALID  in  1  host offers TX_DATA.
TX_READY  out  1  TX FIFO can accept.
RX_DATA  out  Width  head of RX FIFO.
RX_VALID  out  1  RX FIFO non-empty.
RX_READY  in  1  host consumes RX_DATA.
RX_OVR  out  1  sticky overrun flag.
OVR_CLR  in  1  clears RX_OVR.
RX_LEVEL  out  $clog2(RxDepth+1)  RX FIFO occupancy.
TX_LEVEL  out  $clog2(TxDepth+1)  TX FIFO occupancy.
LOOPBACK  in  1  echo mode select (see Optional Feature).

Behaviour:
- Reset: U_OE=0, U_DIN=0, TX_READY=1 (after reset cycle), RX_VALID=0, RX_OVR=0, levels=0, FIFOs empty, TX FSM IDLE. Reset mid-transmission drops all queued bytes. The UART frame already in flight is not aborted.
- FIFOs: write on valid&ready, read on valid&ready. Pointers wrap modulo depth. Level is an explicit counter. Full = level==Depth. Empty = level==0.
- Push and pop in the same cycle: the push is accepted even when full, and the level is unchanged. A pop when empty cannot occur because valid is low.
- RX_DATA is the registered head, with zero-latency show-ahead. A byte pushed at edge N gives RX_VALID=1 after edge N.
- RX path: on U_INT=1, push U_DOUT. If the RX FIFO is full and not popped that cycle, drop the byte and set RX_OVR at the next edge.
- RX_OVR is cleared by OVR_CLR. A set and a clear in the same cycle leaves RX_OVR set.
- TX FSM states:
  - IDLE: if TX FIFO non-empty and U_RDY=1, pop the head into U_DIN and go to STROBE.
  - STROBE: U_OE=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until U_RDY=0, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until U_RDY=1, then go to IDLE.
- U_DIN holds its value from STROBE until the next pop.
- Minimum spacing between U_OE pulses is 4 cycles plus the UART frame time. U_OE is never asserted while U_RDY=0.
- TX_READY = !(TX FIFO full) registered-free, derived combinationally from level.

Optional Feature:
UART_LOOPBACK_EN.
- Defined: when LOOPBACK=1, each U_INT byte is pushed into the TX FIFO instead of the RX FIFO, and TX_READY is forced 0. If the TX FIFO is full, the byte is dropped and RX_OVR is set. The RX FIFO and RX_VALID are untouched and can still drain.
- A LOOPBACK change takes effect on the next cycle. A host write in that same cycle completes normally.
- Undefined: the LOOPBACK port exists but is ignored, and the block behaves as normal bridge mode.

Decomposition:
- Shared include uart_defs.vh: TX FSM state encodings (IDLE, STROBE, WAIT_BUSY, WAIT_IDLE) and the default Width.
- One sub-module, sync_fifo (parameters Width and Depth; ports CLK, RST, push/pop, data, full, empty, level), instantiated twice.
- The bridge holds the TX FSM, overrun logic, and loopback muxing.

Test Plan:
- Host writes 0x41, 0x42, 0x43 back-to-back while U_RDY=1. Expect three U_OE pulses with U_DIN 0x41, 0x42, 0x43 in order, each only after U_RDY has fallen and risen.
- Inject 16 U_INT pulses (0x00..0x0F) with RX_READY=0. Expect RX_LEVEL=16. A 17th byte 0xFF is dropped, RX_OVR=1, and draining yields exactly 0x00..0x0F.
- RX FIFO full, with U_INT and an RX_READY pop in the same cycle. Expect no overrun, RX_LEVEL stays 16, and the new byte appears last.
- Fill the TX FIFO to 16 with U_RDY held 0. Expect TX_READY=0 and no U_OE. Release U_RDY and expect 16 strobes in order.
- Assert RST while WAIT_BUSY with 5 bytes queued. Next cycle expect TX_LEVEL=0, U_OE=0, state IDLE, and no further strobes.
- With UART_LOOPBACK_EN and LOOPBACK=1, inject 0x5A. Expect RX_VALID to stay 0 and a U_OE pulse with U_DIN=0x5A.
